// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side drain stage.
package fifo_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int BEAT_CNT_W = 16;
  localparam int OBUF_DEPTH = 3;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_obuf.sv
// Three-entry register FIFO; entry 0 is the head and drives the stream directly.
module stream_obuf
  import fifo_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [1:0]    occ_o,
  output logic [DW-1:0] head_o
);

  logic [DW-1:0] mem_q [OBUF_DEPTH];
  logic [DW-1:0] mem_d [OBUF_DEPTH];
  occ_t          occ_q, occ_d;
  occ_t          wr_idx;
  logic          pop;

  assign pop = pop_i && (occ_q != '0);

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    mem_d  = mem_q;
    occ_d  = occ_q;
    wr_idx = occ_q;
    if (pop) begin
      for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      wr_idx = occ_q - 2'd1;
      occ_d  = occ_q - 2'd1;
    end
    // A push lands behind the last surviving entry, so push+pop keeps order.
    if (push_i) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        if (wr_idx == occ_t'(i)) mem_d[i] = push_data_i;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  // NOTE: the storage is reset too, so the head register (m_data) is 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      mem_q <= mem_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[0];

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (occ_q == occ_t'(OBUF_DEPTH))));

endmodule

// File: rtl/fifo_stream_drain.sv
// Pops a 1-cycle-latency FIFO with credit-limited reads and presents a framed valid/ready stream.
module fifo_stream_drain
  import fifo_pkg::*;
#(
  parameter int dw      = DW_DEFAULT,
  parameter int PKT_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [dw-1:0]         fifo_dout,
  output logic                  fifo_ren,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [dw-1:0]         m_data,
  output logic                  m_last,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(PKT_LEN - 1);

  logic                  inflight_q;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic [1:0]            occ;
  logic [2:0]            credit_used;
  logic                  xfer;

  stream_obuf #(.DW(dw)) u_obuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .pop_i       (xfer),
    .occ_o       (occ),
    .head_o      (m_data)
  );

  // Credits count the buffer plus the word still in flight; m_ready is deliberately absent.
  assign credit_used = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_ren    = rst_n && drain_en && !fifo_empty && (credit_used < 3'(OBUF_DEPTH));

  assign m_valid  = (occ != 2'd0);
  assign xfer     = m_valid && m_ready;
  assign m_last   = m_valid && (beat_q == LAST_BEAT);
  assign beat_cnt = beat_q;

  always_comb begin
    beat_d = beat_q;
    if (xfer) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= fifo_ren;
      beat_q     <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Self-checking bench: FIFO source model, transaction-level scoreboard, directed and random traffic.
module tb_fifo_stream_drain;
  import fifo_pkg::*;

  localparam int DW      = 32;
  localparam int PKT_LEN = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  drain_en = 1'b0;
  logic                  fifo_empty = 1'b1;
  logic [DW-1:0]         fifo_dout = '0;
  logic                  fifo_ren;
  logic                  m_valid;
  logic                  m_ready = 1'b0;
  logic [DW-1:0]         m_data;
  logic                  m_last;
  logic [BEAT_CNT_W-1:0] beat_cnt;

  fifo_stream_drain #(.dw(DW), .PKT_LEN(PKT_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drain_en   (drain_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ren   (fifo_ren),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_rd, n_xf;
  bit            last_ren;
  bit            force_empty;
  int            last_hits;

  typedef struct {
    bit            de;
    bit            rdy;
    bit            ren;
    bit            valid;
    logic [DW-1:0] data;
    bit            last;
    int            beat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    n_rd     = 0;
    n_xf     = 0;
    last_ren = 1'b0;
  endtask

  task automatic drive(input bit de, input bit rdy, input bit fe);
    drain_en    = de;
    m_ready     = rdy;
    force_empty = fe;
    fifo_empty  = fe || (src_q.size() == 0);
    #2;
  endtask

  // Reference: words read 2+ cycles ago and not yet taken are visible; reads
  // are allowed while fewer than 3 words are read-but-untaken.
  task automatic advance();
    int outst, avail, idx;
    bit ren, xfer;
    outst = n_rd - n_xf;
    avail = outst - int'(last_ren);
    idx   = n_xf % PKT_LEN;
    check("ren", fifo_ren, drain_en && !fifo_empty && (outst < 3));
    check("valid", m_valid, avail > 0);
    check("beat_cnt", beat_cnt, idx);
    check("last", m_last, (avail > 0) && (idx == PKT_LEN - 1));
    if (avail > 0 && exp_q.size() > 0) check("data", m_data, exp_q[0]);
    ren  = fifo_ren;
    xfer = (avail > 0) && m_ready;
    if (xfer && m_last) last_hits++;
    @(posedge clk);
    #1;
    if (xfer) begin
      void'(exp_q.pop_front());
      n_xf++;
    end
    if (ren) begin
      if (src_q.size() > 0) fifo_dout = src_q.pop_front();
      else fifo_dout = 32'hDEAD_BEEF;
      exp_q.push_back(fifo_dout);
      n_rd++;
    end
    last_ren = ren;
  endtask

  task automatic cyc(input bit de, input bit rdy, input bit fe);
    drive(de, rdy, fe);
    advance();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    drain_en   = 1'b1;
    fifo_empty = 1'b0;
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_ren", fifo_ren, 0);
    check("rst_beat", beat_cnt, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    drain_en   = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = (src_q.size() == 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic drain_all(input int budget);
    int c;
    c = 0;
    while ((n_rd != n_xf || src_q.size() > 0) && c < budget) begin
      cyc(1'b1, 1'b1, 1'b0);
      c++;
    end
    check("drain_timeout", c < budget, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cycles, rd0;
    model_clear();
    force_empty = 1'b0;
    do_reset();

    // Latency, stall and framing start: three words, sink stalls two cycles.
    tbl[0] = '{de: 1, rdy: 1, ren: 1, valid: 0, data: 0,      last: 0, beat: 0};
    tbl[1] = '{de: 1, rdy: 1, ren: 1, valid: 0, data: 0,      last: 0, beat: 0};
    tbl[2] = '{de: 1, rdy: 1, ren: 1, valid: 1, data: 'hA5,   last: 0, beat: 0};
    tbl[3] = '{de: 1, rdy: 0, ren: 0, valid: 1, data: 'hB6,   last: 0, beat: 1};
    tbl[4] = '{de: 1, rdy: 0, ren: 0, valid: 1, data: 'hB6,   last: 0, beat: 1};
    tbl[5] = '{de: 1, rdy: 1, ren: 0, valid: 1, data: 'hB6,   last: 0, beat: 1};
    tbl[6] = '{de: 1, rdy: 1, ren: 0, valid: 1, data: 'hC7,   last: 0, beat: 2};
    tbl[7] = '{de: 1, rdy: 1, ren: 0, valid: 0, data: 0,      last: 0, beat: 3};
    src_q.delete();
    src_q.push_back(32'hA5);
    src_q.push_back(32'hB6);
    src_q.push_back(32'hC7);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].de, tbl[i].rdy, 1'b0);
      check($sformatf("tbl%0d_ren", i), fifo_ren, tbl[i].ren);
      check($sformatf("tbl%0d_valid", i), m_valid, tbl[i].valid);
      check($sformatf("tbl%0d_last", i), m_last, tbl[i].last);
      check($sformatf("tbl%0d_beat", i), beat_cnt, tbl[i].beat);
      if (tbl[i].valid) check($sformatf("tbl%0d_data", i), m_data, tbl[i].data);
      advance();
    end

    // Streaming: 40 words, full throughput after a 2-cycle fill.
    src_q.delete();
    do_reset();
    for (int i = 0; i < 40; i++) src_q.push_back(i);
    last_hits = 0;
    cycles    = 0;
    while (n_xf < 40 && cycles < 100) begin
      cyc(1'b1, 1'b1, 1'b0);
      cycles++;
    end
    check("stream_cycles", cycles, 42);
    check("stream_last_hits", last_hits, 2);
    drive(1'b0, 1'b1, 1'b0);
    check("stream_beat_end", beat_cnt, 8);
    check("stream_idle", m_valid, 0);

    // Backpressure: sink stalled 10 cycles with 8 words waiting.
    src_q.delete();
    do_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(32'h100 + i);
    rd0 = n_rd;
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    check("bp_reads", n_rd - rd0, 3);
    drain_all(50);
    check("bp_all_out", n_xf, 8);

    // Empty flag toggling every cycle.
    src_q.delete();
    do_reset();
    for (int i = 0; i < 20; i++) src_q.push_back(32'h200 + i);
    for (int i = 0; i < 60; i++) cyc(1'b1, ($urandom % 4) != 0, i[0]);
    drain_all(100);
    check("empty_all_out", n_xf, 20);

    // drain_en drops after two reads; the in-flight word still arrives.
    src_q.delete();
    do_reset();
    for (int i = 0; i < 6; i++) src_q.push_back(32'h300 + i);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b1, 1'b0);
    check("drop_reads", n_rd, 2);
    check("drop_out", n_xf, 2);
    check("drop_src_left", src_q.size(), 4);

    // Async reset mid-packet with two words buffered.
    src_q.delete();
    do_reset();
    for (int i = 0; i < 40; i++) src_q.push_back(32'h400 + i);
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    do_reset();
    last_hits = 0;
    cycles    = 0;
    while (n_xf < 20 && cycles < 60) begin
      cyc(1'b1, 1'b1, 1'b0);
      cycles++;
    end
    check("rst_mid_out", n_xf, 20);
    check("rst_mid_last_hits", last_hits, 1);

    // Random traffic against the reference model.
    src_q.delete();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 6) == 0) begin
        repeat ($urandom_range(1, 4)) src_q.push_back($urandom);
      end
      cyc(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 5) == 0);
    end
    drain_all(200);
    check("rand_balance", n_rd - n_xf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
Read-side stage directly downstream of the synchronous FIFO. It pops the FIFO through its ren/dout/empty port (1-cycle read latency) and presents the words as a valid/ready stream with packet framing (m_last every PKT_LEN beats). A 3-entry output buffer with credit-based read issue sustains 1 beat/cycle with no combinational path from m_ready to fifo_ren.

Parameters:
dw, 32, data width; must match the FIFO width
PKT_LEN, 16, beats per packet; m_last marks beat PKT_LEN-1; legal range 1..65535

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
drain_en  in  1  1 = new FIFO reads may be issued; 0 = stop issuing reads, in-flight and buffered words still drain
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  dw  FIFO read data, valid the cycle after an accepted ren
fifo_ren  out  1  FIFO read enable (combinational)
m_valid  out  1  stream data valid
m_ready  in  1  stream sink ready
m_data  out  dw  stream data
m_last  out  1  last beat of packet
beat_cnt  out  16  index of the current head beat within its packet

Behaviour:
- Reset (async assert, sync deassert at clk): m_valid=0, m_data=0, m_last=0, beat_cnt=0, buffer empty, inflight=0. fifo_ren=0 while rst_n=0.
- Credit counter: occ (0..3) = buffered words; inflight (0/1) = ren issued last cycle.
- Read issue: fifo_ren = drain_en && !fifo_empty && (occ + inflight) < 3. It is a function of registered state, fifo_empty and drain_en only. It is never a function of m_ready.
- fifo_ren is never asserted while fifo_empty=1, including in the reset-release cycle.
- Capture: if inflight=1 in cycle T, fifo_dout is written into the buffer at the end of T.
- inflight_next = fifo_ren.
- Output: the buffer head drives m_data/m_valid from registers. m_valid=1 whenever occ>0.
- Handshake: a beat transfers on m_valid && m_ready. While m_valid=1 && m_ready=0, m_data and m_last hold stable. m_valid never drops without a transfer.
- Simultaneous push and pop in the same cycle: occ is unchanged and FIFO order is preserved.
- Latency: fifo_ren asserted in cycle T, so m_valid=1 with that word from cycle T+2 (buffer empty case).
- Throughput: with fifo non-empty, drain_en=1 and m_ready=1, one beat transfers per cycle in steady state (occ=1, inflight=1).
- Framing:
  - beat_cnt increments on each transfer and wraps from PKT_LEN-1 to 0.
  - m_last = m_valid && (beat_cnt == PKT_LEN-1).
  - With PKT_LEN=1, m_last=m_valid.
- drain_en falling: the pending inflight word is still captured. The buffer drains normally. beat_cnt is not reset.
- Reset mid-operation: buffered and inflight words are discarded and beat_cnt returns to 0. The FIFO read that was in flight is lost; this is a system-level rule.
- Overflow is impossible by construction. Assert (sim only): capture never occurs when occ=3.

Decomposition:
- Shared package fifo_pkg:
  - DW_DEFAULT=32.
  - BEAT_CNT_W=16.
  - typedef occ_t (2-bit) for buffer occupancy.
- One sub-module: stream_obuf. It is a 3-entry register FIFO with push/pop/occ and registered head output. fifo_stream_drain adds the credit logic, read issue and framing counter around it.

Test Plan:
- Basic latency: FIFO holds 0xA5; empty drops in cycle 0, drain_en=1, m_ready=1. Required: fifo_ren=1 in cycle 0, m_valid=1 with m_data=0xA5 in cycle 2, transfer in cycle 2, m_valid=0 in cycle 3.
- Streaming: 40 words 0..39, m_ready=1, PKT_LEN=16. Required: one beat per cycle after a 2-cycle fill, data in order, m_last on beats 15, 31 only, beat_cnt=8 after beat 39.
- Backpressure: m_ready=0 for 10 cycles with 8 words queued. Required: at most 3 reads issued (occ=3, fifo_ren=0 thereafter), m_data constant. On m_ready=1, words appear in order with no loss or duplicate.
- Empty boundary: FIFO alternates empty/non-empty each cycle. Required: fifo_ren never high while fifo_empty=1, and every read word appears exactly once.
- drain_en drop: deassert drain_en the cycle after a ren. Required: the inflight word still appears on m_data, no further fifo_ren, and the buffered words drain fully.
- Async reset mid-stream: assert rst_n=0 with occ=2 mid-packet. Required: m_valid=0 and fifo_ren=0 immediately. After release, the first beat has beat_cnt=0 and m_last only at beat PKT_LEN-1.
